// File: rtl/arith_pkg.sv
// Shared widths and the packed result entry exchanged between the arithmetic
// micro-operation stage and its result FIFO.
package arith_pkg;

    localparam int DATA_WIDTH = 5;
    localparam int ACC_WIDTH  = 8;

    typedef struct packed {
        logic [1:0]                   s;
        logic                         carry;
        logic signed [DATA_WIDTH-1:0] data;
    } result_t;

endpackage

// File: rtl/sat_accumulator.sv
// Signed accumulator that adds a sign-extended operand on en and clamps the
// result to the representable ACC_WIDTH range; clear wins over en.
module sat_accumulator #(
    parameter int OP_WIDTH  = arith_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH = arith_pkg::ACC_WIDTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        en,
    input  logic signed [OP_WIDTH-1:0]  operand,
    output logic signed [ACC_WIDTH-1:0] accum
);

    localparam int SUM_W = ACC_WIDTH + 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] accum_q, accum_d;
    logic signed [SUM_W-1:0]     sum;
    logic signed [ACC_WIDTH-1:0] sat_sum;

    // One guard bit: the two top bits disagree exactly when the true sum left the range.
    assign sum = $signed({accum_q[ACC_WIDTH-1], accum_q})
               + $signed({{(SUM_W-OP_WIDTH){operand[OP_WIDTH-1]}}, operand});

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sat_sum = sum[ACC_WIDTH-1:0];
        if (sum[SUM_W-1] != sum[SUM_W-2]) begin
            sat_sum = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
        end

        accum_d = accum_q;
        if (clear) begin
            accum_d = '0;
        end else if (en) begin
            accum_d = sat_sum;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            accum_q <= '0;
        end else begin
            accum_q <= accum_d;
        end
    end

    assign accum = accum_q;

endmodule

// File: rtl/arith_result_fifo.sv
// Result FIFO for the arithmetic stage: DEPTH-entry register queue with no
// bypass, a saturating sum of everything popped, and a sticky push-while-full flag.
module arith_result_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = arith_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH  = arith_pkg::ACC_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_s,
    input  logic                          in_carry,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [1:0]                    out_s,
    output logic                          out_carry,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic signed [ACC_WIDTH-1:0]   accum,
    output logic                          overflow,
    input  logic                          clear
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Same layout as arith_pkg::result_t, but follows a DATA_WIDTH override.
    typedef struct packed {
        logic [1:0]                   s;
        logic                         carry;
        logic signed [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               push, pop;
    entry_t             head;

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth lets the pointers wrap by plain overflow.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | (in_valid & ~in_ready);
        if (clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage has no reset; an emptied FIFO hides stale entries via out_valid=0.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{s: in_s, carry: in_carry, data: in_data};
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_s     = head.s;
    assign out_carry = head.carry;
    assign out_data  = head.data;
    assign count     = count_q;
    assign overflow  = overflow_q;

    sat_accumulator #(
        .OP_WIDTH  (DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_accumulator (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .en      (pop),
        .operand (head.data),
        .accum   (accum)
    );

endmodule

// File: tb/tb_arith_result_fifo.sv
// Scoreboard bench for arith_result_fifo: directed scenarios plus random traffic,
// checked every cycle against a queue-and-integer reference model.
module tb_arith_result_fifo;

    localparam int DEPTH   = 4;
    localparam int DW      = 5;
    localparam int AW      = 8;
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int ACC_MAX = 2 ** (AW - 1) - 1;
    localparam int ACC_MIN = -(2 ** (AW - 1));

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [1:0]           in_s = '0;
    logic                 in_carry = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [1:0]           out_s;
    logic                 out_carry;
    logic signed [DW-1:0] out_data;
    logic [CW-1:0]        count;
    logic signed [AW-1:0] accum;
    logic                 overflow;
    logic                 clear = 1'b0;

    arith_result_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_carry  (in_carry),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_carry (out_carry),
        .out_data  (out_data),
        .count     (count),
        .accum     (accum),
        .overflow  (overflow),
        .clear     (clear)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] s;
        logic       c;
        int         d;
    } exp_t;

    exp_t exp_q[$];
    int   acc_m   = 0;
    bit   ovf_m   = 1'b0;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   max_cnt = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        if (v > ACC_MAX) return ACC_MAX;
        if (v < ACC_MIN) return ACC_MIN;
        return v;
    endfunction

    // Monitor: compares the DUT against the model mid-cycle, then advances the model
    // by what the coming rising edge must do.
    always @(negedge clock) begin
        int  n;
        bit  do_push, do_pop;
        if (!reset) begin
            exp_q.delete();
            acc_m = 0;
            ovf_m = 1'b0;
            check("rst_count", count, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_accum", $signed(accum), 0);
            check("rst_overflow", overflow, 0);
        end else begin
            n = exp_q.size();
            if (n > max_cnt) max_cnt = n;
            check("count", count, n);
            check("in_ready", in_ready, (n != DEPTH) ? 1 : 0);
            check("out_valid", out_valid, (n != 0) ? 1 : 0);
            check("accum", $signed(accum), acc_m);
            check("overflow", overflow, ovf_m);
            if (n > 0) begin
                check("out_s", out_s, exp_q[0].s);
                check("out_carry", out_carry, exp_q[0].c);
                check("out_data", $signed(out_data), exp_q[0].d);
            end
            do_pop  = (n != 0) && out_ready;
            do_push = in_valid && (n != DEPTH);
            if (clear) begin
                acc_m = 0;
                ovf_m = 1'b0;
            end else begin
                if (do_pop) acc_m = sat(acc_m + exp_q[0].d);
                if (in_valid && n == DEPTH) ovf_m = 1'b1;
            end
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back('{in_s, in_carry, int'($signed(in_data))});
        end
    end

    // Apply one cycle of inputs, let the edge happen, return 1 time unit after it.
    task automatic drive(input logic v, input logic [1:0] s, input logic c,
                         input logic [DW-1:0] d, input logic ordy, input logic clr);
        in_valid  = v;
        in_s      = s;
        in_carry  = c;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic ordy, input logic clr);
        drive(1'b0, 2'b00, 1'b0, '0, ordy, clr);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // Three pushes with the output stalled.
        drive(1'b1, 2'b01, 1'b0, DW'(3), 1'b0, 1'b0);
        drive(1'b1, 2'b01, 1'b0, DW'(-2), 1'b0, 1'b0);
        drive(1'b1, 2'b01, 1'b0, DW'(7), 1'b0, 1'b0);
        check("s1_count", count, 3);
        check("s1_out_data", $signed(out_data), 3);
        check("s1_in_ready", in_ready, 1);
        check("s1_accum", $signed(accum), 0);

        // Fill, then push once more while full.
        drive(1'b1, 2'b10, 1'b1, DW'(5), 1'b0, 1'b0);
        drive(1'b1, 2'b11, 1'b1, DW'(9), 1'b0, 1'b0);
        check("s2_in_ready", in_ready, 0);
        check("s2_overflow", overflow, 1);
        check("s2_count", count, 4);

        // Push and pop together while full: only the pop happens.
        drive(1'b1, 2'b00, 1'b0, DW'(10), 1'b1, 1'b0);
        check("s3_count_after_pop", count, 3);
        drive(1'b1, 2'b00, 1'b1, DW'(11), 1'b0, 1'b0);
        check("s3_count_refill", count, 4);
        repeat (4) idle(1'b1, 1'b0);
        check("s3_accum", $signed(accum), 24);
        check("s3_empty", out_valid, 0);
        idle(1'b0, 1'b1);
        check("s3_clear_accum", $signed(accum), 0);
        check("s3_clear_ovf", overflow, 0);

        // Positive and negative saturation.
        repeat (10) drive(1'b1, 2'b01, 1'b0, DW'(15), 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("s4_pos_sat", $signed(accum), 127);
        idle(1'b0, 1'b1);
        repeat (10) drive(1'b1, 2'b10, 1'b1, DW'(-16), 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("s4_neg_sat", $signed(accum), -128);
        idle(1'b0, 1'b1);

        // Streaming through: pointers wrap twice, occupancy stays at 1.
        max_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i), i[0], DW'(i * 3 - 10), 1'b1, 1'b0);
        end
        idle(1'b1, 1'b0);
        check("s5_max_count", max_cnt, 1);
        check("s5_drained", count, 0);

        // Build accum=40, overflow=1, count=2, then clear with a pop.
        idle(1'b0, 1'b1);
        drive(1'b1, 2'b00, 1'b0, DW'(10), 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        repeat (4) drive(1'b1, 2'b01, 1'b1, DW'(15), 1'b0, 1'b0);
        drive(1'b1, 2'b01, 1'b1, DW'(1), 1'b0, 1'b0);
        repeat (2) idle(1'b1, 1'b0);
        check("s6_accum", $signed(accum), 40);
        check("s6_overflow", overflow, 1);
        check("s6_count", count, 2);
        idle(1'b1, 1'b1);
        check("s6_clr_accum", $signed(accum), 0);
        check("s6_clr_ovf", overflow, 0);
        check("s6_clr_count", count, 1);

        // Asynchronous reset in the middle of a cycle.
        drive(1'b1, 2'b10, 1'b1, DW'(4), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("s7_async_count", count, 0);
        check("s7_async_out_valid", out_valid, 0);
        check("s7_async_in_ready", in_ready, 1);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // Random traffic: first slow drain (fills up), then fast drain.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), DW'($urandom),
                  (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 24) == 0);
        end
        repeat (6) idle(1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_result_fifo.md
ARITH_RESULT_FIFO -- requirements
Module: arith_result_fifo

Interface
REQ-001 The module SHALL take parameter DEPTH, default 4, the number of FIFO entries (power of two, >= 2).
REQ-002 The module SHALL take parameter DATA_WIDTH, default 5, the signed result width from the arithmetic micro-operation stage.
REQ-003 The module SHALL take parameter ACC_WIDTH, default 8, the signed accumulator width.
REQ-004 clock  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in_valid  input  1  upstream result valid.
REQ-007 in_ready  output  1  FIFO can accept; equals (count != DEPTH).
REQ-008 in_s  input  2  operation select tag of the result.
REQ-009 in_carry  input  1  carry tag of the result.
REQ-010 in_data  input  DATA_WIDTH  signed result.
REQ-011 out_valid  output  1  head entry present; equals (count != 0).
REQ-012 out_ready  input  1  downstream accepts head.
REQ-013 out_s, out_carry, out_data  output  2/1/DATA_WIDTH  head entry fields.
REQ-014 count  output  clog2(DEPTH)+1  occupancy, 0..DEPTH.
REQ-015 accum  output  ACC_WIDTH  signed saturating sum of all popped out_data.
REQ-016 overflow  output  1  sticky: a push was attempted while full.
REQ-017 clear  input  1  synchronous clear of accum and overflow only.

Function
REQ-018 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-019 Occupancy states: EMPTY (count 0), PARTIAL (0<count<DEPTH), FULL (count DEPTH); transitions only by push/pop, one step per cycle.
REQ-020 Push-only: count+1; pop-only: count-1; simultaneous push and pop: count unchanged, both pointers advance.
REQ-021 In FULL, in_ready is 0, so no push occurs even with a same-cycle pop; the freed slot is usable next cycle.
REQ-022 In EMPTY, out_valid is 0, so no pop occurs; there is no input-to-output bypass.
REQ-023 Latency: an entry pushed at edge N SHALL appear on out_* with out_valid=1 after edge N when the FIFO was empty.
REQ-024 out_* SHALL present the oldest entry, unchanged, until it is popped; order is strictly FIFO.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-026 On a pop, accum SHALL become sat(accum + sign-extended out_data), clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
REQ-027 overflow SHALL set on any cycle with in_valid=1 and in_ready=0, and SHALL hold until clear or reset; the rejected entry is discarded.
REQ-028 clear=1 SHALL force accum=0 and overflow=0 at the next edge, taking priority over a same-cycle pop or overflow event; FIFO contents and pops are unaffected.
REQ-029 out_data values are treated as two's-complement signed; in_s and in_carry are carried through untouched.

Reset
REQ-030 While reset=0: count=0, pointers=0, out_valid=0, in_ready=1, accum=0, overflow=0, immediately (asynchronous).
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; storage contents need not be cleared, but out_* are don't-care while out_valid=0.
REQ-032 Deassertion SHALL take effect at the first rising edge after reset goes high.

Structure
REQ-033 DATA_WIDTH, ACC_WIDTH and a packed result entry type {s[1:0], carry, data} SHALL live in a shared package arith_pkg, also used by the arithmetic micro-operation stage.
REQ-034 The saturating add SHALL be a sub-module sat_accumulator (inputs: clock, reset, clear, en, signed operand; output: accum).
REQ-035 Storage SHALL be a DEPTH-entry register array inside arith_result_fifo.

Verification
REQ-036 Reset then push 3,-2,7 (s=01,carry=0) with out_ready=0 -> count=3, out_data=3, in_ready=1, accum=0.
REQ-037 Fill to 4 entries, hold in_valid=1 one extra cycle -> in_ready=0, overflow=1, count stays 4, fifth value never appears at the output.
REQ-038 With FIFO full, assert in_valid and out_ready together -> count 3 after the edge; the next cycle's push restores count 4; the output order matches the push order.
REQ-039 Push 15 ten times and pop each time -> accum sequence 15,30,...,120,127,127 (saturated); repeat with -16 -> clamps at -128.
REQ-040 Push 8 entries while popping continuously -> pointers wrap, all 8 values exit in order, count never exceeds 1.
REQ-041 With accum=40, overflow=1, count=2, assert clear together with a pop -> accum=0, overflow=0, count=1; assert reset=0 mid-stream -> count=0, out_valid=0 immediately.
